// File: rtl/tdm_demux18_pkg.sv
// Shared definitions for the TDM lane mux/demux pair.
// TDM_DEMUX_PARITY_EN adds one even-parity beat per frame.
package tdm_pkg;

  localparam int LANES_DEF = 8;
  localparam int SEL_W_DEF = 3;

  typedef logic [LANES_DEF-1:0] lane_word_t;
  typedef logic [SEL_W_DEF-1:0] lane_sel_t;

  // 0 = even parity; the transmit-side mux uses the same constant
  localparam logic PARITY_POL = 1'b0;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int CNT_EXTRA = 1;
`else
  localparam int CNT_EXTRA = 0;
`endif

  typedef enum logic {ST_HUNT, ST_LOCKED} lock_state_e;

endpackage

// File: rtl/tdm_demux18_if.sv
// Serial-in / word-out bundle of the TDM 1:8 demultiplexer.
interface tdm_demux18_if
  import tdm_pkg::*;
#(
  parameter int LANES = LANES_DEF
);
  logic             din;
  logic             din_valid;
  logic             frame_sync;
  logic             out_ready;
  logic [LANES-1:0] lanes_out;
  logic             out_valid;
  logic             locked;
  logic             sync_err;
  logic             overrun;
  logic             parity_err;

  modport master (
    output din, din_valid, frame_sync, out_ready,
    input  lanes_out, out_valid, locked, sync_err, overrun, parity_err
  );

  modport slave (
    input  din, din_valid, frame_sync, out_ready,
    output lanes_out, out_valid, locked, sync_err, overrun, parity_err
  );
endinterface

// File: rtl/tdm_demux18_lane_counter.sv
// Lane counter, lock tracking and resync detection for tdm_demux18.
// TDM_DEMUX_PARITY_EN extends the count by one beat for the parity bit.
module tdm_lane_counter
  import tdm_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int CNT_W = SEL_W + CNT_EXTRA
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_din_valid,
  input  logic             i_frame_sync,
  output logic             o_locked,
  output logic             o_sync_err,
  output logic             o_we,
  output logic [CNT_W-1:0] o_sel,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANES - 1 + CNT_EXTRA);

  lock_state_e      r_state;
  lock_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sync_err;
  logic             w_sync_err_nxt;
  logic             w_we;
  logic             w_done;
  logic [CNT_W-1:0] w_sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_HUNT;
      r_cnt      <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sync_err <= w_sync_err_nxt;
    end
  end

  // A sync beat always lands in lane 0 and leaves the count at 1
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sync_err_nxt = 1'b0;
    w_we           = 1'b0;
    w_done         = 1'b0;
    w_sel          = r_cnt;
    if (i_din_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (i_frame_sync) begin
            w_state_nxt = ST_LOCKED;
            w_cnt_nxt   = CNT_W'(1);
            w_we        = 1'b1;
            w_sel       = '0;
          end
        end
        default: begin
          if (i_frame_sync && (r_cnt != '0)) begin
            w_sync_err_nxt = 1'b1;
            w_cnt_nxt      = CNT_W'(1);
            w_we           = 1'b1;
            w_sel          = '0;
          end else begin
            // the final beat is consumed straight from din, never stored
            w_we = (r_cnt != CNT_LAST);
            if (r_cnt == CNT_LAST) begin
              w_cnt_nxt = '0;
              w_done    = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign o_locked   = (r_state == ST_LOCKED);
  assign o_sync_err = r_sync_err;
  assign o_we       = w_we;
  assign o_sel      = w_sel;
  assign o_done     = w_done;

endmodule

// File: rtl/tdm_demux18.sv
// TDM 1:8 demultiplexer: serial bits framed by frame_sync become 8-lane words on valid/ready.
// Define TDM_DEMUX_PARITY_EN to append and check an even-parity beat per frame.
module tdm_demux18
  import tdm_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux18_if.slave  bus
);

  localparam int CNT_W    = SEL_W + CNT_EXTRA;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int SHADOW_W = LANES;
`else
  localparam int SHADOW_W = LANES - 1;
`endif

  logic                w_locked;
  logic                w_sync_err;
  logic                w_we;
  logic                w_done;
  logic [CNT_W-1:0]    w_sel;
  logic [LANES-1:0]    w_word;
  logic                w_bad;
  logic [SHADOW_W-1:0] r_shadow;
  logic [LANES-1:0]    r_word;
  logic                r_valid;
  logic                r_overrun;
  logic                r_perr;

  tdm_lane_counter #(
    .LANES (LANES),
    .SEL_W (SEL_W),
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_din_valid  (bus.din_valid),
    .i_frame_sync (bus.frame_sync),
    .o_locked     (w_locked),
    .o_sync_err   (w_sync_err),
    .o_we         (w_we),
    .o_sel        (w_sel),
    .o_done       (w_done)
  );

`ifdef TDM_DEMUX_PARITY_EN
  assign w_word = r_shadow;
  assign w_bad  = (^r_shadow) ^ bus.din ^ PARITY_POL;
`else
  assign w_word = {bus.din, r_shadow};
  assign w_bad  = 1'b0;
`endif

  // A completed word loads when the holding slot is empty or being drained this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_perr <= 1'b0;
      for (int k = 0; k < SHADOW_W; k++) begin
        if (w_we && (w_sel == CNT_W'(k))) r_shadow[k] <= bus.din;
      end
      if (w_done) begin
        if (!r_valid || bus.out_ready) begin
          r_word  <= w_word;
          r_valid <= 1'b1;
          r_perr  <= w_bad;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && bus.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.lanes_out  = r_word;
  assign bus.out_valid  = r_valid;
  assign bus.locked     = w_locked;
  assign bus.sync_err   = w_sync_err;
  assign bus.overrun    = r_overrun;
  assign bus.parity_err = r_perr;

endmodule

// File: tb/tb_tdm_demux18.sv
// Directed scoreboard bench for tdm_demux18 (default and TDM_DEMUX_PARITY_EN builds).
module tb_tdm_demux18;
  import tdm_pkg::*;

  localparam int LANES = LANES_DEF;

  typedef struct {
    logic [LANES-1:0] word;
    logic             perr;
    int               cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   se_cnt = 0;
  exp_t q[$];
  exp_t e_mon;
  logic prev_v   = 1'b0;
  logic prev_acc = 1'b0;
  logic [LANES-1:0] prev_w = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tdm_demux18_if #(.LANES(LANES)) bus ();

  tdm_demux18 #(.LANES(LANES), .SEL_W(SEL_W_DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per out_valid rise
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sync_err) se_cnt++;
      if (bus.out_valid && !prev_v) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %0h expected none", bus.lanes_out);
        end else begin
          e_mon = q.pop_front();
          chk("word", 32'(bus.lanes_out), 32'(e_mon.word));
          chk("parity_err", 32'(bus.parity_err), 32'(e_mon.perr));
          chk("latency_cycle", 32'(cyc), 32'(e_mon.cyc));
        end
      end else if (bus.parity_err) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_parity_err: got 1 expected 0");
      end
      if (bus.out_valid && prev_v && !prev_acc)
        chk("hold_stable", 32'(bus.lanes_out), 32'(prev_w));
    end
    prev_v   = bus.out_valid && rst_n;
    prev_acc = bus.out_valid && bus.out_ready;
    prev_w   = bus.lanes_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic beat(input logic d, input logic s);
    bus.din        = d;
    bus.din_valid  = 1'b1;
    bus.frame_sync = s;
    @(posedge clk);
    #1;
    bus.din        = 1'b0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [LANES-1:0] w, input logic s, input int gap,
                            input logic pflip, output int last);
    for (int k = 0; k < LANES; k++) begin
      beat(w[k], s && (k == 0));
`ifdef TDM_DEMUX_PARITY_EN
      if (gap > 0) idle(gap);
`else
      if (gap > 0 && k < LANES - 1) idle(gap);
`endif
    end
`ifdef TDM_DEMUX_PARITY_EN
    beat((^w) ^ PARITY_POL ^ pflip, 1'b0);
`else
    if (pflip) idle(0);
`endif
    last = cyc;
  endtask

  task automatic push(input logic [LANES-1:0] w, input logic perr, input int c);
    exp_t e;
    e.word = w;
    e.perr = perr;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.frame_sync = 1'b0;
    #2;
    chk("rst_lanes_out", 32'(bus.lanes_out), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_locked", 32'(bus.locked), 32'h0);
    chk("rst_sync_err", 32'(bus.sync_err), 32'h0);
    chk("rst_overrun", 32'(bus.overrun), 32'h0);
    chk("rst_parity_err", 32'(bus.parity_err), 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    int last;
    int se0;
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.frame_sync = 1'b0; bus.out_ready = 1'b1;
    idle(1);
    do_reset();

    // Basic frame 1,0,1,1,0,0,1,0 -> 8'h4D
    send_frame(8'h4D, 1'b1, 0, 1'b0, last);
    push(8'h4D, 1'b0, last);
    chk("t1_locked", 32'(bus.locked), 32'h1);
    @(negedge clk);
    chk("t1_valid_high", 32'(bus.out_valid), 32'h1);
    @(negedge clk);
    chk("t1_valid_one_cycle", 32'(bus.out_valid), 32'h0);
    @(posedge clk); #1;

    // Reset mid-frame, then unsynced beats are discarded
    for (int k = 0; k < 4; k++) beat(1'b1, 1'b0);
    do_reset();
    send_frame(8'hC3, 1'b0, 0, 1'b0, last);
    idle(1);
    chk("t2_unlocked", 32'(bus.locked), 32'h0);
    chk("t2_no_valid", 32'(bus.out_valid), 32'h0);
    send_frame(8'hFF, 1'b1, 0, 1'b0, last);
    push(8'hFF, 1'b0, last);
    chk("t2_locked", 32'(bus.locked), 32'h1);
    idle(2);

    // Overrun: A5 held, 3C dropped
    bus.out_ready = 1'b0;
    send_frame(8'hA5, 1'b1, 0, 1'b0, last);
    push(8'hA5, 1'b0, last);
    chk("t3_no_overrun_yet", 32'(bus.overrun), 32'h0);
    send_frame(8'h3C, 1'b0, 0, 1'b0, last);
    chk("t3_overrun", 32'(bus.overrun), 32'h1);
    chk("t3_held_word", 32'(bus.lanes_out), 32'hA5);
    chk("t3_held_valid", 32'(bus.out_valid), 32'h1);
    bus.out_ready = 1'b1;
    idle(1);
    chk("t3_accepted", 32'(bus.out_valid), 32'h0);
    idle(2);

    // Resync at lane 5 over a partial frame of ones
    se0 = se_cnt;
    for (int k = 0; k < 5; k++) beat(1'b1, 1'b0);
    send_frame(8'h96, 1'b1, 0, 1'b0, last);
    push(8'h96, 1'b0, last);
    idle(2);
    chk("t4_sync_err_pulses", 32'(se_cnt - se0), 32'h1);

    // din_valid toggling every cycle
    send_frame(8'h5A, 1'b0, 1, 1'b0, last);
    push(8'h5A, 1'b0, last);
    idle(2);

    // Back-to-back frames, no gap
    send_frame(8'h81, 1'b1, 0, 1'b0, last);
    push(8'h81, 1'b0, last);
    send_frame(8'h7E, 1'b0, 0, 1'b0, last);
    push(8'h7E, 1'b0, last);
    idle(2);

`ifdef TDM_DEMUX_PARITY_EN
    send_frame(8'h07, 1'b1, 0, 1'b1, last);
    push(8'h07, 1'b1, last);
    send_frame(8'h07, 1'b0, 0, 1'b0, last);
    push(8'h07, 1'b0, last);
    idle(2);
`endif

    idle(3);
    chk("end_queue_empty", 32'(q.size()), 32'h0);
    chk("end_sync_err_total", 32'(se_cnt), 32'h1);
    chk("end_overrun_sticky", 32'(bus.overrun), 32'h1);
    chk("end_locked", 32'(bus.locked), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux18.md
Name: tdm_demux18

Overview:
- Time-division 1:8 demultiplexer with a serial-to-parallel front end.
- Takes a serial bit stream framed by a sync marker and steers bit k of each frame into lane k.
- Presents each completed 8-lane word on a valid/ready output.
- It is the receive-side counterpart of the team's 8:1 lane multiplexer driven by a rotating select.

Parameters:
- LANES, 8, number of lanes per frame (must be a power of two, ≥2).
- SEL_W, 3, width of the lane counter, equal to log2(LANES).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  din and frame_sync are sampled only when high.
- frame_sync  input  1  marks the current din as lane 0 of a new frame.
- lanes_out  output  LANES  completed word; bit k = lane k.
- out_valid  output  1  lanes_out holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- locked  output  1  a frame_sync has been seen since reset.
- sync_err  output  1  one-cycle pulse: frame_sync arrived mid-frame.
- overrun  output  1  sticky: a completed word was dropped. Cleared only by reset.
- parity_err  output  1  one-cycle pulse on parity mismatch (PARITY_EN only). Tied 0 otherwise.

Behaviour:
- Reset (async assert, sync release):
  - lanes_out=0, out_valid=0, locked=0, sync_err=0, overrun=0, parity_err=0.
  - Lane counter=0, shadow register=0.
- Unlocked (locked=0): all din_valid beats are discarded until a beat with frame_sync=1. That beat is lane 0. locked goes to 1 the next cycle and stays 1 until reset.
- Locked, per valid beat:
  - shadow[cnt] <= din; cnt <= cnt+1, wrapping LANES-1 -> 0.
  - Beats with din_valid=0 leave all state unchanged.
- Frame complete: the beat with cnt==LANES-1 completes the frame.
  - The next cycle, the word {din, shadow[LANES-2:0]} is transferred to lanes_out and out_valid=1.
  - Latency is one clock from the last bit's sampling edge.
- Handshake:
  - out_valid stays high and lanes_out stays stable until out_valid && out_ready.
  - out_valid clears the cycle after acceptance, unless a new word is delivered that same edge. In that case out_valid stays 1 with the new data, so back-to-back delivery is allowed.
- Overrun:
  - Frame completes while out_valid=1 and out_ready=0: the new word is dropped, the held word is kept, and overrun is set.
  - Completion and acceptance on the same edge is not an overrun.
- Resync:
  - frame_sync=1 on a valid beat with cnt≠0: the partial frame is discarded, din is stored as lane 0, cnt<=1, and sync_err pulses for one cycle.
  - frame_sync on a beat with cnt==0 is normal, with no error.
- Frames without sync: absence of frame_sync at cnt==0 is legal. The counter free-runs from the free-running alignment.
- Reset mid-frame: the partial frame is lost and the block returns to unlocked.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- When defined:
  - Each frame has LANES+1 beats; the last beat is an even-parity bit over the LANES data bits.
  - The counter spans 0..LANES. The word is delivered after the parity beat, still with one-clock latency.
  - On mismatch the word is still delivered and parity_err pulses for one cycle, aligned with the out_valid rise for that word.
  - Resync and overrun rules apply unchanged, counting the parity beat as part of the frame.
- When undefined: frames are LANES beats and parity_err is constant 0.

Decomposition:
- Shared package tdm_pkg holds:
  - LANES_DEF=8 and SEL_W_DEF=3.
  - typedef lane_word_t (logic [LANES_DEF-1:0]).
  - typedef lane_sel_t (logic [SEL_W_DEF-1:0]).
  - The parity polarity constant, shared with the transmit-side multiplexer.
- One natural sub-module: tdm_lane_counter. It owns the counter, lock flag, resync detection and the frame-complete strobe. The top handles the shadow register, output holding register and handshake.

Test Plan:
- Reset then sync + serial 1,0,1,1,0,0,1,0 (lane0 first), out_ready=1 -> lanes_out=8'h4D, out_valid for one cycle, one clock after the last bit.
- Eight valid beats before any frame_sync -> out_valid stays 0, locked=0. Then sync + 8'hFF bits -> locked=1 and lanes_out=8'hFF.
- Two back-to-back frames 8'hA5 then 8'h3C with out_ready=0 throughout -> lanes_out holds 8'hA5 and overrun=1. Raise out_ready -> 8'hA5 is accepted, no 8'h3C appears.
- frame_sync asserted at lane 5 -> sync_err pulses once, then the following 8 bits of 8'h96 deliver 8'h96 with no stale bits.
- din_valid toggled 1/0 every cycle during frame 8'h5A -> same word delivered, with latency measured from the last valid beat.
- PARITY_EN: frame 8'h07 + parity bit 0 (wrong) -> lanes_out=8'h07, parity_err pulse coincident with the out_valid rise. Correct parity 1 -> no pulse.
